vga_sync_receiver: RTL and testbench

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

---
 rtl/vga_sync_receiver.sv | 149 ++++++++++++++
 tb/tb_vga_sync_receiver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// Recovers 640x480@60 raster position from HS/VS, measures line/frame length,
// tracks lock to the nominal total, and captures the pixel at a probe coordinate.
module vga_sync_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 783,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 514
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        HS,
  input  logic        VS,
  input  logic [2:0]  R,
  input  logic [2:0]  G,
  input  logic [1:0]  B,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        active,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic        locked,
  output logic [7:0]  probe_pix,
  output logic        probe_valid,
  output logic [7:0]  err_count
);

  localparam logic [10:0] CNT_MAX = 11'd2047;
  localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
  localparam logic [10:0] HA0     = 11'(H_ACT_START);
  localparam logic [10:0] HA1     = 11'(H_ACT_END);
  localparam logic [10:0] VA0     = 11'(V_ACT_START);
  localparam logic [10:0] VA1     = 11'(V_ACT_END);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t      state, state_n;
  logic        hs_prev, vs_prev, vs_pend, line_bad, line_bad_n;
  logic        hs_fall, vs_fall, frame_edge, line_ok, frame_ok, lose_lock, hit;
  logic [10:0] hcount_n, vcount_n, meas_len, meas_lines, px, py;

  function automatic logic in_active(input logic [10:0] h, input logic [10:0] v);
    return (h >= HA0) && (h <= HA1) && (v >= VA0) && (v <= VA1);
  endfunction

  // Next counter values are what a pixel sampled on this edge is tagged with.
  always_comb begin
    hs_fall    = hs_prev & ~HS;
    vs_fall    = vs_prev & ~VS;
    frame_edge = hs_fall & (vs_pend | vs_fall);
    meas_len   = hcount + 11'd1;
    meas_lines = vcount + 11'd1;
    line_ok    = (meas_len == H_TOT);
    frame_ok   = (meas_lines == V_TOT);
    if (hs_fall)                hcount_n = '0;
    else if (hcount == CNT_MAX) hcount_n = CNT_MAX;
    else                        hcount_n = hcount + 11'd1;
    vcount_n = vcount;
    if (frame_edge)                         vcount_n = '0;
    else if (hs_fall && vcount != CNT_MAX)  vcount_n = vcount + 11'd1;
    px  = hcount_n - HA0;
    py  = vcount_n - VA0;
    hit = pix_en & locked & in_active(hcount_n, vcount_n)
          & (px == {1'b0, probe_x}) & (py == {1'b0, probe_y});
  end

  assign active = in_active(hcount, vcount);
  assign locked = (state == LOCKED);

  always_comb begin
    state_n    = state;
    line_bad_n = line_bad;
    lose_lock  = 1'b0;
    if (pix_en) begin
      case (state)
        SEARCH: begin
          if (frame_edge) begin
            state_n    = CHECK;
            line_bad_n = 1'b0;
          end
        end
        CHECK: begin
          // The line closed by the boundary edge still belongs to the frame under test.
          if (frame_edge) begin
            state_n    = (!line_bad && line_ok && frame_ok) ? LOCKED : CHECK;
            line_bad_n = 1'b0;
          end else if (hs_fall && !line_ok) begin
            line_bad_n = 1'b1;
          end
        end
        LOCKED: begin
          if ((hs_fall && !line_ok) || (frame_edge && !frame_ok) || (hcount_n == CNT_MAX)) begin
            state_n   = SEARCH;
            lose_lock = 1'b1;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      line_bad <= 1'b0;
    end else begin
      state    <= state_n;
      line_bad <= line_bad_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      vs_pend     <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      probe_pix   <= '0;
      probe_valid <= 1'b0;
      err_count   <= '0;
    end else begin
      probe_valid <= hit;
      if (hit) probe_pix <= {R, G, B};
      if (pix_en) begin
        hs_prev <= HS;
        vs_prev <= VS;
        hcount  <= hcount_n;
        vcount  <= vcount_n;
        if (hs_fall) line_len <= meas_len;
        if (frame_edge) begin
          frame_lines <= meas_lines;
          vs_pend     <= 1'b0;
        end else if (vs_fall) begin
          vs_pend <= 1'b1;
        end
      end
      if (lose_lock && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a shrunken 12x5 raster so that
// lock, relock and saturation scenarios fit in a short run.
module tb_vga_sync_receiver;
  localparam int HT = 12, VT = 5, HSW = 2, VSW = 1;
  localparam int HA0 = 3, HA1 = 9, VA0 = 1, VA1 = 3;

  logic        clk = 1'b0;
  logic        rst_n, pix_en, HS, VS;
  logic [2:0]  R, G;
  logic [1:0]  B;
  logic [9:0]  probe_x, probe_y;
  logic [10:0] hcount, vcount, line_len, frame_lines;
  logic        active, locked, probe_valid;
  logic [7:0]  probe_pix, err_count;

  int checks = 0, failures = 0, pe_div = 4, pv_cnt = 0, pv_base;
  bit chk_on = 1'b1, probe_mode = 1'b0;

  typedef struct {
    logic hs; logic vs;
    logic [10:0] hc; logic [10:0] vc; logic [10:0] ll; logic [10:0] fl;
    logic act;
  } vec_t;
  vec_t tbl [16];

  vga_sync_receiver #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HA0), .H_ACT_END(HA1),
    .V_ACT_START(VA0), .V_ACT_END(VA1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .HS(HS), .VS(VS),
    .R(R), .G(G), .B(B), .probe_x(probe_x), .probe_y(probe_y),
    .hcount(hcount), .vcount(vcount), .active(active),
    .line_len(line_len), .frame_lines(frame_lines), .locked(locked),
    .probe_pix(probe_pix), .probe_valid(probe_valid), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (probe_valid === 1'b1) pv_cnt <= pv_cnt + 1;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [7:0] pattern(input int j, input int v);
    return 8'(j) ^ 8'(v * 16);
  endfunction

  task automatic pix(input logic hs, input logic vs, input logic [7:0] rgb);
    repeat (pe_div - 1) begin @(posedge clk); #1; end
    HS = hs; VS = vs; {R, G, B} = rgb; pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
  endtask

  task automatic line(input int jend, input int v, input int j0);
    for (int j = j0; j < jend; j++) begin
      logic [7:0] rgb;
      rgb = (probe_mode && j == HA0 && v == VA0) ? 8'hFF : pattern(j, v);
      pix((j < HSW) ? 1'b0 : 1'b1, (v < VSW) ? 1'b0 : 1'b1, rgb);
      if (chk_on) begin
        chk("hcount", hcount, j);
        chk("vcount", vcount, v);
        chk("active", active, (j >= HA0 && j <= HA1 && v >= VA0 && v <= VA1));
      end
    end
  endtask

  task automatic frame_part(input int v0, input int v1, input int bad);
    for (int v = v0; v <= v1; v++) line((v == bad) ? HT - 1 : HT, v, 0);
  endtask

  // Two boundaries: first enters CHECK, second must land in LOCKED.
  task automatic relock();
    line(1, 0, 0);
    chk("locked_after_b1", locked, 0);
    chk("vcount_b1", vcount, 0);
    line(HT, 0, 1);
    frame_part(1, VT - 1, -1);
    chk("locked_before_b2", locked, 0);
    line(1, 0, 0);
    chk("locked_after_b2", locked, 1);
    chk("line_len", line_len, HT);
    chk("frame_lines", frame_lines, VT);
    line(HT, 0, 1);
    frame_part(1, VT - 1, -1);
  endtask

  task automatic check_reset();
    chk("rst_hcount", hcount, 0);
    chk("rst_vcount", vcount, 0);
    chk("rst_line_len", line_len, 0);
    chk("rst_frame_lines", frame_lines, 0);
    chk("rst_active", active, 0);
    chk("rst_locked", locked, 0);
    chk("rst_probe_pix", probe_pix, 0);
    chk("rst_probe_valid", probe_valid, 0);
    chk("rst_err_count", err_count, 0);
  endtask

  task automatic do_reset();
    HS = 1'b1; VS = 1'b1; pix_en = 1'b0; {R, G, B} = 8'h00;
    rst_n = 1'b0;
    #1;
    check_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // hs, vs -> hcount, vcount, line_len, frame_lines, active (from reset, unlocked)
    tbl[0]  = '{1'b0, 1'b1, 11'd0, 11'd1, 11'd1, 11'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 11'd1, 11'd1, 11'd1, 11'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 11'd2, 11'd1, 11'd1, 11'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 11'd3, 11'd1, 11'd1, 11'd0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 11'd4, 11'd1, 11'd1, 11'd0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 11'd5, 11'd1, 11'd1, 11'd0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 11'd0, 11'd0, 11'd6, 11'd2, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 11'd1, 11'd0, 11'd6, 11'd2, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 11'd2, 11'd0, 11'd6, 11'd2, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 11'd0, 11'd1, 11'd3, 11'd2, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 11'd1, 11'd1, 11'd3, 11'd2, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 11'd0, 11'd2, 11'd2, 11'd2, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 11'd1, 11'd2, 11'd2, 11'd2, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 11'd0, 11'd0, 11'd2, 11'd3, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 11'd1, 11'd0, 11'd2, 11'd3, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 11'd2, 11'd0, 11'd2, 11'd3, 1'b0};

    rst_n = 1'b1; pix_en = 1'b0; HS = 1'b1; VS = 1'b1;
    {R, G, B} = 8'h00; probe_x = '0; probe_y = '0;
    #2;
    do_reset();

    for (int i = 0; i < 16; i++) begin
      pix(tbl[i].hs, tbl[i].vs, 8'h00);
      chk($sformatf("tbl%0d_hcount", i), hcount, tbl[i].hc);
      chk($sformatf("tbl%0d_vcount", i), vcount, tbl[i].vc);
      chk($sformatf("tbl%0d_line_len", i), line_len, tbl[i].ll);
      chk($sformatf("tbl%0d_frame_lines", i), frame_lines, tbl[i].fl);
      chk($sformatf("tbl%0d_active", i), active, tbl[i].act);
      chk($sformatf("tbl%0d_locked", i), locked, 0);
    end

    do_reset();
    relock();

    // Probe at visible origin: one capture per frame.
    probe_mode = 1'b1; probe_x = 10'd0; probe_y = 10'd0;
    for (int f = 0; f < 2; f++) begin
      pv_base = pv_cnt;
      frame_part(0, VT - 1, -1);
      chk("probe_pulses_origin", pv_cnt - pv_base, 1);
      chk("probe_pix_origin", probe_pix, 8'hFF);
    end
    probe_mode = 1'b0; probe_x = 10'd2; probe_y = 10'd1;
    pv_base = pv_cnt;
    frame_part(0, VT - 1, -1);
    chk("probe_pulses_2_1", pv_cnt - pv_base, 1);
    chk("probe_pix_2_1", probe_pix, pattern(HA0 + 2, VA0 + 1));

    // Short line while locked; no capture until relocked.
    probe_x = 10'd0; probe_y = 10'd2;
    pv_base = pv_cnt;
    frame_part(0, 2, 2);
    chk("locked_before_short_meas", locked, 1);
    line(1, 3, 0);
    chk("locked_after_short", locked, 0);
    chk("err_after_short", err_count, 1);
    line(HT, 3, 1);
    line(HT, 4, 0);
    chk("probe_pulses_unlocked", pv_cnt - pv_base, 0);
    chk("probe_pix_held", probe_pix, pattern(HA0 + 2, VA0 + 1));
    relock();
    chk("probe_pulses_relock", pv_cnt - pv_base, 1);
    chk("probe_pix_relock", probe_pix, pattern(HA0, VA0 + 2));
    chk("err_after_relock", err_count, 1);

    // HS stuck high until hcount saturates.
    line(2047, 0, 0);
    chk("locked_hc2046", locked, 1);
    line(2048, 0, 2047);
    chk("locked_hc2047", locked, 0);
    chk("err_hc_sat", err_count, 2);
    pix(1'b1, 1'b0, 8'h00);
    chk("hcount_saturated", hcount, 2047);
    frame_part(1, VT - 1, -1);
    relock();
    chk("err_after_sat_relock", err_count, 2);

    pe_div = 1;
    for (int k = 0; k < 298; k++) begin
      frame_part(0, VT - 1, 2);
      frame_part(0, VT - 1, -1);
      if (k == 251) chk("err_254", err_count, 254);
      if (k == 252) chk("err_255", err_count, 255);
    end
    chk("err_saturated", err_count, 255);
    pe_div = 4;

    // Reset in the middle of a locked frame.
    line(1, 0, 0);
    chk("locked_before_rst", locked, 1);
    line(HT, 0, 1);
    line(HT, 1, 0);
    line(5, 2, 0);
    do_reset();
    relock();
    chk("err_after_midframe_rst", err_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
